port_fifo: RTL and testbench
============================

PORT_FIFO -- requirements
Module: port_fifo

Interface
REQ-001 SHALL have parameter Width, default 64, meaning data word width in bits.
REQ-002 SHALL have parameter AddrBits, default 5, meaning log2 of storage depth (Depth = 2^AddrBits = 32).
REQ-003 SHALL have parameter BpSlack, default 4, meaning words the sender may still push after seeing D_BP.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 D  input  Width  write data from router port.
REQ-007 D_VALID  input  1  write strobe, one word per cycle.
REQ-008 D_BP  output  1  backpressure to sender, registered.
REQ-009 Q  output  Width  read data to PE port, registered.
REQ-010 Q_VALID  output  1  Q holds a word this cycle; push protocol, no ready.
REQ-011 Q_BP  input  1  downstream backpressure.
REQ-012 FREEZE  input  1  suppress output (partial-reconfiguration freeze).
REQ-013 FLUSH  input  1  synchronous clear of all buffered words.
REQ-014 LEVEL  output  AddrBits+1  current stored word count.
REQ-015 OVERFLOW  output  1  sticky: a word arrived while full.

Function
REQ-016 Write: at an edge with D_VALID=1 and count<Depth, D SHALL be stored at wptr; wptr increments, wrapping mod Depth.
REQ-017 Read: at an edge with count>0, Q_BP=0, FREEZE=0, FLUSH=0, the word at rptr SHALL load Q, Q_VALID=1 for the next cycle, rptr wraps mod Depth; otherwise Q_VALID=0 next cycle and Q holds its value.
REQ-018 Latency: a word written at edge k into an empty FIFO with Q_BP=0 SHALL appear with Q_VALID=1 after edge k+1.
REQ-019 Count SHALL use pre-edge values: simultaneous read and write leave count unchanged; count never exceeds Depth nor underflows.
REQ-020 D_BP SHALL be 1 after any edge at which the new count >= Depth-BpSlack, else 0.
REQ-021 Full: D_VALID=1 with count=Depth and no read in the same edge SHALL drop the word and set OVERFLOW=1 until RST; with a simultaneous read the word SHALL be accepted.
REQ-022 Q_BP and FREEZE SHALL affect only reads; writes continue while frozen.
REQ-023 FLUSH=1 at an edge SHALL zero count, wptr, rptr and Q_VALID, discard any same-edge write, and SHALL not clear OVERFLOW.
REQ-024 Word order SHALL be preserved exactly across wrap-around; no word is duplicated or lost except per REQ-021/REQ-023.
REQ-025 LEVEL SHALL equal count after each edge.

Reset
REQ-026 RST=1 SHALL immediately force count=0, wptr=0, rptr=0, Q_VALID=0, Q=0, D_BP=0, OVERFLOW=0, independent of CLK.
REQ-027 Buffered words SHALL be discarded when RST asserts mid-transfer; storage contents need not reset.
REQ-028 The first write after RST deassertion SHALL be accepted at the first edge with D_VALID=1.

Structure
REQ-029 Default Width and the valid/backpressure signal conventions SHALL come from the shared project header used by router and PE ports.
REQ-030 Storage SHALL be one sub-module, port_fifo_ram: simple dual-port, synchronous write, synchronous read, Depth x Width, no reset.
REQ-031 Pointers, count, flags and output register SHALL live in port_fifo; parameter check: BpSlack < Depth.

Verification
REQ-032 Write 0x01..0x05 on consecutive edges, Q_BP=0 -> Q_VALID from edge after first write, Q=0x01..0x05 in order, LEVEL returns to 0.
REQ-033 Q_BP=1, write 28 words -> D_BP rises after edge of 28th write; write 4 more -> LEVEL=32, OVERFLOW=0; 33rd word -> dropped, OVERFLOW=1.
REQ-034 Full FIFO, Q_BP=0, D_VALID=1 continuous -> LEVEL stays 32, no drop, OVERFLOW=0, output sequence gap-free.
REQ-035 Write 40 words with Q_BP toggling every 3 cycles -> all 40 out in order across pointer wrap, LEVEL ends 0.
REQ-036 FREEZE=1 while writing 6 words -> Q_VALID=0, LEVEL=6; FREEZE=0 -> 6 words emitted; then FLUSH with LEVEL=10 and D_VALID=1 -> LEVEL=0, Q_VALID=0, OVERFLOW unchanged.
REQ-037 Assert RST asynchronously mid-burst with LEVEL=12 -> outputs per REQ-026 before next edge; post-reset write 0xAA -> Q=0xAA, Q_VALID=1 one edge later.

Source files
------------

// File: rtl/port_fifo_pkg.sv
// Shared router/PE port conventions: default word width, active levels of
// valid/backpressure strobes, and the backpressure threshold helper.
package port_fifo_pkg;

   localparam int   PF_DEFAULT_WIDTH = 64;
   localparam logic PF_VALID_ON      = 1'b1;
   localparam logic PF_BP_ON         = 1'b1;

   function automatic logic pf_bp_due(input int unsigned level, input int unsigned thresh);
      logic due;
      if (level >= thresh) begin
         due = PF_BP_ON;
      end else begin
         due = ~PF_BP_ON;
      end
      return due;
   endfunction

endpackage

// File: rtl/port_fifo_if.sv
// Word stream between router and PE ports: data + valid forward, bp backward.
interface port_fifo_if
   import port_fifo_pkg::*;
#(
   parameter int Width = PF_DEFAULT_WIDTH
) ();

   logic [Width-1:0] data;
   logic             valid;
   logic             bp;

   modport master (output data, output valid, input bp);
   modport slave  (input data, input valid, output bp);

endinterface

// File: rtl/port_fifo_ram.sv
// Simple dual-port Depth x Width storage, synchronous write and read, no reset.
module port_fifo_ram
   import port_fifo_pkg::*;
#(
   parameter int Width    = PF_DEFAULT_WIDTH,
   parameter int AddrBits = 5
) (
   input  logic                i_clk,
   input  logic                i_wr_en,
   input  logic [AddrBits-1:0] i_wr_addr,
   input  logic [Width-1:0]    i_wr_data,
   input  logic [AddrBits-1:0] i_rd_addr,
   output logic [Width-1:0]    o_rd_data
);

   logic [Width-1:0] r_mem [0:(1 << AddrBits)-1];
   logic [Width-1:0] r_rd_data;

   // write port
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // read port, returns pre-edge contents on an address collision
   always_ff @(posedge i_clk) begin
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/port_fifo.sv
// Router-to-PE word buffer: registered push output, early backpressure with
// slack, sticky overflow, freeze and flush. Storage lives in port_fifo_ram.
module port_fifo
   import port_fifo_pkg::*;
#(
   parameter int Width    = PF_DEFAULT_WIDTH,
   parameter int AddrBits = 5,
   parameter int BpSlack  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   port_fifo_if.slave        i_wr,
   port_fifo_if.master       o_rd,
   input  logic              i_freeze,
   input  logic              i_flush,
   output logic [AddrBits:0] o_level,
   output logic              o_overflow
);

   localparam int unsigned         Depth    = 1 << AddrBits;
   localparam int unsigned         BpThresh = Depth - BpSlack;
   localparam logic [AddrBits:0]   CNT_FULL = (AddrBits+1)'(Depth);
   localparam logic [AddrBits:0]   CNT_ZERO = (AddrBits+1)'(32'd0);
   localparam logic [AddrBits:0]   CNT_ONE  = (AddrBits+1)'(32'd1);
   localparam logic [AddrBits-1:0] PTR_ZERO = AddrBits'(32'd0);
   localparam logic [AddrBits-1:0] PTR_ONE  = AddrBits'(32'd1);

   if (BpSlack >= Depth) begin : g_bad_slack
      $error("port_fifo: BpSlack must be smaller than the storage depth");
   end

   logic [AddrBits:0]   r_count;
   logic [AddrBits-1:0] r_wptr;
   logic [AddrBits-1:0] r_rptr;
   logic                r_d_bp;
   logic                r_overflow;
   logic [Width-1:0]    r_q;
   logic                r_q_valid;
   logic                r_byp;
   logic [Width-1:0]    r_byp_data;

   logic                w_full;
   logic                w_rd_fire;
   logic                w_wr_fire;
   logic                w_drop;
   logic [AddrBits:0]   w_count_nxt;
   logic [AddrBits-1:0] w_wptr_nxt;
   logic [AddrBits-1:0] w_rptr_nxt;
   logic                w_byp_nxt;
   logic [Width-1:0]    w_ram_q;

   // The RAM is always addressed with the post-edge read pointer so the next
   // word is already waiting in its read register; a word written at the same
   // edge to that slot is not visible yet and is taken from the bypass.
   port_fifo_ram #(
      .Width    (Width),
      .AddrBits (AddrBits)
   ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr_fire),
      .i_wr_addr (r_wptr),
      .i_wr_data (i_wr.data),
      .i_rd_addr (w_rptr_nxt),
      .o_rd_data (w_ram_q)
   );

   // next-state for pointers, count and the write bypass
   always_comb begin
      w_full      = (r_count == CNT_FULL);
      w_rd_fire   = (r_count != CNT_ZERO) && !o_rd.bp && !i_freeze && !i_flush;
      w_wr_fire   = i_wr.valid && !i_flush && (!w_full || w_rd_fire);
      w_drop      = i_wr.valid && !i_flush && w_full && !w_rd_fire;
      w_count_nxt = r_count;
      w_wptr_nxt  = r_wptr;
      w_rptr_nxt  = r_rptr;
      if (i_flush) begin
         w_count_nxt = CNT_ZERO;
         w_wptr_nxt  = PTR_ZERO;
         w_rptr_nxt  = PTR_ZERO;
      end else begin
         w_wptr_nxt = r_wptr + (w_wr_fire ? PTR_ONE : PTR_ZERO);
         w_rptr_nxt = r_rptr + (w_rd_fire ? PTR_ONE : PTR_ZERO);
         case ({w_wr_fire, w_rd_fire})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
         endcase
      end
      w_byp_nxt = w_wr_fire && (r_wptr == w_rptr_nxt);
   end

   // control state and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count    <= CNT_ZERO;
         r_wptr     <= PTR_ZERO;
         r_rptr     <= PTR_ZERO;
         r_d_bp     <= ~PF_BP_ON;
         r_overflow <= 1'b0;
         r_q        <= {Width{1'b0}};
         r_q_valid  <= ~PF_VALID_ON;
         r_byp      <= 1'b0;
         r_byp_data <= {Width{1'b0}};
      end else begin
         r_count    <= w_count_nxt;
         r_wptr     <= w_wptr_nxt;
         r_rptr     <= w_rptr_nxt;
         r_d_bp     <= pf_bp_due(32'(w_count_nxt), BpThresh);
         r_overflow <= r_overflow | w_drop;
         r_byp      <= w_byp_nxt;
         r_byp_data <= i_wr.data;
         if (w_rd_fire) begin
            r_q       <= r_byp ? r_byp_data : w_ram_q;
            r_q_valid <= PF_VALID_ON;
         end else begin
            r_q_valid <= ~PF_VALID_ON;
         end
      end
   end

   assign i_wr.bp    = r_d_bp;
   assign o_rd.data  = r_q;
   assign o_rd.valid = r_q_valid;
   assign o_level    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_port_fifo.sv
// Self-checking bench for port_fifo against a queue-based reference model.
module tb_port_fifo;

   localparam int W     = 64;
   localparam int AB    = 5;
   localparam int SL    = 4;
   localparam int DEPTH = 32;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          freeze = 1'b0;
   logic          flush  = 1'b0;
   logic [AB:0]   level;
   logic          ovf;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mdl[$];
   logic [W-1:0] m_q   = '0;
   bit           m_qv  = 1'b0;
   bit           m_ovf = 1'b0;
   bit           m_dbp = 1'b0;

   port_fifo_if #(.Width(W)) wr_if ();
   port_fifo_if #(.Width(W)) rd_if ();

   port_fifo #(.Width(W), .AddrBits(AB), .BpSlack(SL)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr       (wr_if),
      .o_rd       (rd_if),
      .i_freeze   (freeze),
      .i_flush    (flush),
      .o_level    (level),
      .o_overflow (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] rnd_word();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      mdl.delete();
      m_q   = '0;
      m_qv  = 1'b0;
      m_ovf = 1'b0;
      m_dbp = 1'b0;
   endtask

   // one clock edge: the model consumes the inputs held across the edge
   task automatic cycle();
      bit rd;
      @(posedge clk);
      rd = (mdl.size() != 0) && !rd_if.bp && !freeze && !flush;
      if (flush) begin
         mdl.delete();
         m_qv = 1'b0;
      end else begin
         m_qv = rd;
         if (rd) m_q = mdl.pop_front();
         if (wr_if.valid) begin
            if (mdl.size() < DEPTH) mdl.push_back(wr_if.data);
            else m_ovf = 1'b1;
         end
      end
      m_dbp = (mdl.size() >= DEPTH - SL);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_if.valid = 1'b0; wr_if.data = '0; rd_if.bp = 1'b0;
      model_reset();
      #12;
      total++; if (level !== 6'd0)     begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
      total++; if (rd_if.valid !== 1'b0) begin bad++; $display("FAIL reset_qvalid got=%b exp=0", rd_if.valid); end
      total++; if (rd_if.data !== '0)  begin bad++; $display("FAIL reset_q got=%h exp=0", rd_if.data); end
      total++; if (wr_if.bp !== 1'b0)  begin bad++; $display("FAIL reset_dbp got=%b exp=0", wr_if.bp); end
      total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] got[$];
      rd_if.bp = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         wr_if.valid = (i <= 5);
         wr_if.data  = W'(i);
         cycle();
         if (rd_if.valid === 1'b1) got.push_back(rd_if.data);
         total++; if (rd_if.valid !== m_qv) begin bad++; $display("FAIL basic_qvalid cyc=%0d got=%b exp=%b", i, rd_if.valid, m_qv); end
         total++; if (rd_if.data !== m_q)   begin bad++; $display("FAIL basic_q cyc=%0d got=%h exp=%h", i, rd_if.data, m_q); end
         total++; if (level !== 6'(mdl.size())) begin bad++; $display("FAIL basic_level cyc=%0d got=%0d exp=%0d", i, level, mdl.size()); end
      end
      total++; if (got.size() != 5) begin bad++; $display("FAIL basic_count got=%0d exp=5", got.size()); end
      for (int k = 0; k < got.size() && k < 5; k++) begin
         total++; if (got[k] !== W'(k + 1)) begin bad++; $display("FAIL basic_order idx=%0d got=%h exp=%0d", k, got[k], k + 1); end
      end
      total++; if (level !== 6'd0) begin bad++; $display("FAIL basic_final_level got=%0d exp=0", level); end
   endtask

   task automatic test_fill_overflow();
      rd_if.bp = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         wr_if.valid = 1'b1;
         wr_if.data  = rnd_word();
         cycle();
         total++; if (level !== 6'((i > 32) ? 32 : i)) begin bad++; $display("FAIL fill_level i=%0d got=%0d", i, level); end
         total++; if (wr_if.bp !== (i >= 28)) begin bad++; $display("FAIL fill_dbp i=%0d got=%b exp=%b", i, wr_if.bp, (i >= 28)); end
         total++; if (ovf !== (i >= 33))      begin bad++; $display("FAIL fill_ovf i=%0d got=%b exp=%b", i, ovf, (i >= 33)); end
         total++; if (rd_if.valid !== 1'b0)   begin bad++; $display("FAIL fill_qvalid i=%0d got=%b exp=0", i, rd_if.valid); end
      end
      wr_if.valid = 1'b0;
   endtask

   task automatic test_full_stream();
      rst = 1'b1; #2; rst = 1'b0;
      model_reset();
      rd_if.bp = 1'b1;
      for (int i = 0; i < 32; i++) begin
         wr_if.valid = 1'b1; wr_if.data = rnd_word(); cycle();
      end
      rd_if.bp = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wr_if.data = rnd_word();
         cycle();
         total++; if (level !== 6'd32)        begin bad++; $display("FAIL stream_level i=%0d got=%0d exp=32", i, level); end
         total++; if (ovf !== 1'b0)           begin bad++; $display("FAIL stream_ovf i=%0d got=%b exp=0", i, ovf); end
         total++; if (rd_if.valid !== 1'b1)   begin bad++; $display("FAIL stream_gap i=%0d got=%b exp=1", i, rd_if.valid); end
         total++; if (rd_if.data !== m_q)     begin bad++; $display("FAIL stream_q i=%0d got=%h exp=%h", i, rd_if.data, m_q); end
      end
      wr_if.valid = 1'b0;
      for (int i = 0; i < 40 && mdl.size() != 0; i++) begin
         cycle();
         total++; if (rd_if.data !== m_q) begin bad++; $display("FAIL stream_drain_q i=%0d got=%h exp=%h", i, rd_if.data, m_q); end
      end
      total++; if (level !== 6'd0) begin bad++; $display("FAIL stream_drain_level got=%0d exp=0", level); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] sent[$];
      logic [W-1:0] got[$];
      for (int i = 0; i < 40; i++) begin
         rd_if.bp    = ((i / 3) % 2) == 1;
         wr_if.valid = 1'b1;
         wr_if.data  = rnd_word();
         sent.push_back(wr_if.data);
         cycle();
         if (rd_if.valid === 1'b1) got.push_back(rd_if.data);
         total++; if (level !== 6'(mdl.size())) begin bad++; $display("FAIL wrap_level i=%0d got=%0d exp=%0d", i, level, mdl.size()); end
         total++; if (rd_if.valid !== m_qv)     begin bad++; $display("FAIL wrap_qvalid i=%0d got=%b exp=%b", i, rd_if.valid, m_qv); end
      end
      wr_if.valid = 1'b0;
      rd_if.bp    = 1'b0;
      for (int i = 0; i < 50 && got.size() < 40; i++) begin
         cycle();
         if (rd_if.valid === 1'b1) got.push_back(rd_if.data);
      end
      total++; if (got.size() != 40) begin bad++; $display("FAIL wrap_count got=%0d exp=40", got.size()); end
      for (int k = 0; k < got.size() && k < 40; k++) begin
         total++; if (got[k] !== sent[k]) begin bad++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", k, got[k], sent[k]); end
      end
      total++; if (level !== 6'd0) begin bad++; $display("FAIL wrap_final_level got=%0d exp=0", level); end
   endtask

   task automatic test_freeze_flush();
      logic [W-1:0] sent[$];
      bit           ovf_before;
      freeze = 1'b1; rd_if.bp = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         wr_if.valid = 1'b1; wr_if.data = rnd_word(); sent.push_back(wr_if.data);
         cycle();
         total++; if (rd_if.valid !== 1'b0) begin bad++; $display("FAIL frz_qvalid i=%0d got=%b exp=0", i, rd_if.valid); end
         total++; if (level !== 6'(i))       begin bad++; $display("FAIL frz_level i=%0d got=%0d exp=%0d", i, level, i); end
      end
      freeze = 1'b0; wr_if.valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         total++; if (rd_if.valid !== 1'b1)   begin bad++; $display("FAIL thaw_qvalid i=%0d got=%b exp=1", i, rd_if.valid); end
         total++; if (rd_if.data !== sent[i]) begin bad++; $display("FAIL thaw_q i=%0d got=%h exp=%h", i, rd_if.data, sent[i]); end
      end
      rd_if.bp = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr_if.valid = 1'b1; wr_if.data = rnd_word(); cycle();
      end
      total++; if (level !== 6'd10) begin bad++; $display("FAIL preflush_level got=%0d exp=10", level); end
      ovf_before = m_ovf;
      flush = 1'b1; rd_if.bp = 1'b0;
      cycle();
      total++; if (level !== 6'd0)       begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
      total++; if (rd_if.valid !== 1'b0) begin bad++; $display("FAIL flush_qvalid got=%b exp=0", rd_if.valid); end
      total++; if (ovf !== ovf_before)   begin bad++; $display("FAIL flush_ovf got=%b exp=%b", ovf, ovf_before); end
      flush = 1'b0; wr_if.valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++; if (rd_if.valid !== 1'b0) begin bad++; $display("FAIL postflush_qvalid i=%0d got=%b exp=0", i, rd_if.valid); end
      end
   endtask

   task automatic test_async_reset();
      rd_if.bp = 1'b1;
      for (int i = 0; i < 33; i++) begin
         wr_if.valid = 1'b1; wr_if.data = rnd_word(); cycle();
      end
      flush = 1'b1;
      cycle();
      total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL flush_keeps_ovf got=%b exp=1", ovf); end
      total++; if (level !== 6'd0) begin bad++; $display("FAIL flush_full_level got=%0d exp=0", level); end
      flush = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wr_if.data = rnd_word(); cycle();
      end
      total++; if (level !== 6'd12) begin bad++; $display("FAIL prerst_level got=%0d exp=12", level); end
      #3 rst = 1'b1;
      #1;
      model_reset();
      total++; if (level !== 6'd0)       begin bad++; $display("FAIL arst_level got=%0d exp=0", level); end
      total++; if (rd_if.valid !== 1'b0) begin bad++; $display("FAIL arst_qvalid got=%b exp=0", rd_if.valid); end
      total++; if (rd_if.data !== '0)    begin bad++; $display("FAIL arst_q got=%h exp=0", rd_if.data); end
      total++; if (wr_if.bp !== 1'b0)    begin bad++; $display("FAIL arst_dbp got=%b exp=0", wr_if.bp); end
      total++; if (ovf !== 1'b0)         begin bad++; $display("FAIL arst_ovf got=%b exp=0", ovf); end
      wr_if.data = W'(8'hAA); wr_if.valid = 1'b1; rd_if.bp = 1'b0;
      #1 rst = 1'b0;
      cycle();
      total++; if (level !== 6'd1)       begin bad++; $display("FAIL aa_level got=%0d exp=1", level); end
      total++; if (rd_if.valid !== 1'b0) begin bad++; $display("FAIL aa_early_qvalid got=%b exp=0", rd_if.valid); end
      wr_if.valid = 1'b0;
      cycle();
      total++; if (rd_if.valid !== 1'b1)      begin bad++; $display("FAIL aa_qvalid got=%b exp=1", rd_if.valid); end
      total++; if (rd_if.data !== W'(8'hAA))  begin bad++; $display("FAIL aa_q got=%h exp=aa", rd_if.data); end
      total++; if (level !== 6'd0)            begin bad++; $display("FAIL aa_final_level got=%0d exp=0", level); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_stream();
      test_wrap();
      test_freeze_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
